wb_select_stage: RTL and testbench
==================================

Name: wb_select_stage

Overview:
- Parametrised, registered successor to the CPU's combinational writeback-source mux.
- Selects one of NSRC WIDTH-bit sources (ALU result, memory read data, PC+4, immediate, ...) and registers the result for the writeback stage.
- Adds a memory-ready handshake with pipeline stall, a bounded wait timeout, and defined handling of out-of-range selects; the old 2-bit mux latched on those.

Parameters:
- WIDTH, 32, data width of every source and of the output.
- NSRC, 4, number of source channels; must be at least 2.
- MEM_SRC, 1, index of the source that must wait for mem_rdy; must be less than NSRC.
- TIMEOUT, 15, maximum cycles spent in WAIT_MEM before forced completion; must be at least 1.
- SELW, clog2(NSRC), localparam, select width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sel/in_data describe a writeback request this cycle.
- sel  in  SELW  source index.
- in_data  in  NSRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- mem_rdy  in  1  memory read data on source MEM_SRC is valid this cycle.
- stall  out  1  combinational; upstream must hold sel/in_data and not advance.
- out_valid  out  1  registered; one-cycle pulse per completed request.
- out_data  out  WIDTH  registered result; holds its value between pulses.
- sel_err  out  1  registered; pulses with out_valid when sel was at least NSRC.
- mem_timeout  out  1  registered; pulses with out_valid when the wait timed out.

Behaviour:
- Reset: state=IDLE, out_valid=0, out_data=0, sel_err=0, mem_timeout=0, wait counter=0. Reset mid-WAIT_MEM abandons the request; no out_valid is produced.
- FSM states: IDLE, WAIT_MEM.
- IDLE, in_valid=0: no capture; out_valid=0 next cycle.
- IDLE, in_valid=1 and sel<NSRC and sel!=MEM_SRC: capture slice sel. Next cycle out_valid=1 with that data. Latency 1.
- IDLE, in_valid=1 and sel=MEM_SRC and mem_rdy=1: capture slice MEM_SRC. Latency 1, no stall.
- IDLE, in_valid=1 and sel=MEM_SRC and mem_rdy=0: stall=1 this cycle. Go to WAIT_MEM, counter=1.
- IDLE, in_valid=1 and sel>=NSRC: next cycle out_valid=1, out_data=0, sel_err=1. Latency 1, no stall.
- WAIT_MEM: stall=1 every cycle. in_valid and sel are ignored; upstream is holding them.
- WAIT_MEM, mem_rdy=1: capture slice MEM_SRC, pulse out_valid next cycle, return to IDLE.
- WAIT_MEM, mem_rdy=0: counter increments.
- WAIT_MEM, mem_rdy=0 and counter=TIMEOUT: next cycle out_valid=1, out_data=0, mem_timeout=1; return to IDLE.
- mem_rdy and the timeout in the same cycle: mem_rdy wins; the data is captured and mem_timeout=0.
- Stall logic: stall = (state==WAIT_MEM) or (state==IDLE and in_valid and sel==MEM_SRC and not mem_rdy). stall is low whenever in_valid=0 in IDLE.
- Back-to-back: a new request is accepted in the same cycle WAIT_MEM completes, never earlier. Consecutive non-memory requests yield one out_valid per cycle.
- sel_err and mem_timeout are 0 whenever out_valid=0, and are never both 1.
- Counter width: clog2(TIMEOUT+1); no wrap-around is possible.

Decomposition:
- Shared package: WIDTH default (the existing Bus width), writeback-source index constants (SRC_ALU=0, SRC_MEM=1, SRC_PC4=2, SRC_IMM=3), FSM state encoding.
- One natural sub-module: wb_src_mux, a purely combinational NSRC-way slice select that returns 0 for an out-of-range sel.
- FSM, counter and output registers stay in wb_select_stage.

Test Plan:
- Reset, then in_valid=1, sel=0, source0=32'h0000_1234 -> one cycle later out_valid=1, out_data=32'h0000_1234, stall never asserted.
- sel=1 with mem_rdy=0 for 3 cycles then 1, source1=32'hDEAD_BEEF -> stall high for 4 cycles; out_valid=1 with 32'hDEAD_BEEF the cycle after mem_rdy; mem_timeout=0.
- sel=1 with mem_rdy held 0, TIMEOUT=15 -> stall high 16 cycles; out_valid=1, out_data=0, mem_timeout=1; FSM back in IDLE.
- NSRC=3, sel=2'b11 -> next cycle out_valid=1, out_data=0, sel_err=1; out_data then holds 0 while in_valid=0.
- Assert rst during WAIT_MEM cycle 2 -> all outputs 0 the next cycle, no out_valid; a following sel=2 request (PC+4=32'h0000_0040) completes normally.
- Four consecutive requests sel=0,2,3,0 -> out_valid high for 4 consecutive cycles with the matching data, stall stays 0.

Source files
------------

// File: rtl/wb_select_stage_pkg.sv
// Shared writeback-select definitions: bus width, source indices,
// and the select-stage FSM state encoding.
package wb_select_stage_pkg;

  localparam int XLEN     = 32;
  localparam int NSRC_DEF = 4;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_PC4 = 2;
  localparam int SRC_IMM = 3;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// NSRC-way combinational slice select; out-of-range sel yields 0.
// Ports: sel, packed in_data in; out_data slice and sel_ok out.
module wb_src_mux #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2
) (
  input  logic [SELW-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]      out_data,
  output logic                  sel_ok
);

  always_comb begin
    out_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(sel) == k) begin
        out_data = in_data[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_select_stage.sv
// Registered writeback-source select with memory-ready stall/timeout.
// Ports: clk, rst, in_valid, sel, in_data, mem_rdy in; stall, out_* out.
module wb_select_stage
  import wb_select_stage_pkg::*;
#(
  parameter  int WIDTH   = XLEN,
  parameter  int NSRC    = NSRC_DEF,
  parameter  int MEM_SRC = SRC_MEM,
  parameter  int TIMEOUT = 15,
  localparam int SELW    = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [SELW-1:0]       sel,
  input  logic [NSRC*WIDTH-1:0] in_data,
  input  logic                  mem_rdy,
  output logic                  stall,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  sel_err,
  output logic                  mem_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [SELW-1:0] MEM_SEL = SELW'(MEM_SRC);
  localparam logic [CW-1:0]   TO_CNT  = CW'(TIMEOUT);

  wb_state_e        state;
  logic [CW-1:0]    cnt;
  logic [SELW-1:0]  mux_sel;
  logic [WIDTH-1:0] mux_data;
  logic             sel_ok;
  logic             is_mem;

  // While waiting, the held sel is ignored and the memory slice is forced.
  assign mux_sel = (state == WAIT_MEM) ? MEM_SEL : sel;
  assign is_mem  = (sel == MEM_SEL);

  assign stall = (state == WAIT_MEM) ||
                 (in_valid && is_mem && !mem_rdy);

  wb_src_mux #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SELW  (SELW)
  ) u_mux (
    .sel      (mux_sel),
    .in_data  (in_data),
    .out_data (mux_data),
    .sel_ok   (sel_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      sel_err     <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      sel_err     <= 1'b0;
      mem_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (!sel_ok) begin
              out_valid <= 1'b1;
              out_data  <= '0;
              sel_err   <= 1'b1;
            end else if (is_mem && !mem_rdy) begin
              state <= WAIT_MEM;
              cnt   <= CW'(1);
            end else begin
              out_valid <= 1'b1;
              out_data  <= mux_data;
            end
          end
        end
        WAIT_MEM: begin
          // mem_rdy takes priority over an expiring wait
          if (mem_rdy) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
            state     <= IDLE;
            cnt       <= '0;
          end else if (cnt == TO_CNT) begin
            out_valid   <= 1'b1;
            out_data    <= '0;
            mem_timeout <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: NSRC=4 and NSRC=3 instances on shared
// stimulus, a cycle model, directed literal checks and random traffic.
module tb_wb_select_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         mem_rdy = 1'b0;
  logic [1:0]   sel = 2'd0;
  logic [4*W-1:0] in_data = '0;

  logic         stall_a, ov_a, se_a, to_a;
  logic [W-1:0] od_a;
  logic         stall_b, ov_b, se_b, to_b;
  logic [W-1:0] od_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_select_stage dut_a (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .sel         (sel),
    .in_data     (in_data),
    .mem_rdy     (mem_rdy),
    .stall       (stall_a),
    .out_valid   (ov_a),
    .out_data    (od_a),
    .sel_err     (se_a),
    .mem_timeout (to_a)
  );

  wb_select_stage #(.NSRC(3)) dut_b (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .sel         (sel),
    .in_data     (in_data[3*W-1:0]),
    .mem_rdy     (mem_rdy),
    .stall       (stall_b),
    .out_valid   (ov_b),
    .out_data    (od_b),
    .sel_err     (se_b),
    .mem_timeout (to_b)
  );

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [W-1:0] v);
    in_data[k*W +: W] = v;
  endtask

  // Reference model: per instance, whether a memory request is pending
  // and for how many cycles it has been stalled so far.
  int           nsrc[2] = '{4, 3};
  bit           waiting[2];
  int           waited[2];
  bit           m_v[2], m_se[2], m_to[2];
  logic [W-1:0] m_d[2];
  bit           armed = 1'b0;

  logic         a_st, a_v, a_se, a_to, e_st;
  logic [W-1:0] a_d;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      a_st = (k == 0) ? stall_a : stall_b;
      a_v  = (k == 0) ? ov_a : ov_b;
      a_se = (k == 0) ? se_a : se_b;
      a_to = (k == 0) ? to_a : to_b;
      a_d  = (k == 0) ? od_a : od_b;
      e_st = waiting[k] || (in_valid && sel == 2'd1 && !mem_rdy);
      if (armed) begin
        chk($sformatf("m_stall%0d", k), W'(a_st), W'(e_st));
        chk($sformatf("m_valid%0d", k), W'(a_v), W'(m_v[k]));
        chk($sformatf("m_data%0d", k), a_d, m_d[k]);
        chk($sformatf("m_selerr%0d", k), W'(a_se), W'(m_se[k]));
        chk($sformatf("m_tmo%0d", k), W'(a_to), W'(m_to[k]));
      end
      if (rst) begin
        waiting[k] = 1'b0;
        waited[k]  = 0;
        m_v[k]     = 1'b0;
        m_se[k]    = 1'b0;
        m_to[k]    = 1'b0;
        m_d[k]     = '0;
      end else begin
        m_v[k]  = 1'b0;
        m_se[k] = 1'b0;
        m_to[k] = 1'b0;
        if (waiting[k]) begin
          if (mem_rdy) begin
            m_v[k]     = 1'b1;
            m_d[k]     = in_data[W +: W];
            waiting[k] = 1'b0;
          end else if (waited[k] == 15) begin
            m_v[k]     = 1'b1;
            m_d[k]     = '0;
            m_to[k]    = 1'b1;
            waiting[k] = 1'b0;
          end else begin
            waited[k]++;
          end
        end else if (in_valid) begin
          if (int'(sel) >= nsrc[k]) begin
            m_v[k]  = 1'b1;
            m_d[k]  = '0;
            m_se[k] = 1'b1;
          end else if (sel == 2'd1 && !mem_rdy) begin
            waiting[k] = 1'b1;
            waited[k]  = 1;
          end else begin
            m_v[k] = 1'b1;
            m_d[k] = in_data[int'(sel)*W +: W];
          end
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  int n;
  bit got;
  int p;
  logic [1:0]   seq_s[4] = '{2'd0, 2'd2, 2'd3, 2'd0};
  logic [W-1:0] seq_d[4] = '{32'hA000_0000, 32'hA000_0002,
                             32'hA000_0003, 32'hA000_0004};

  initial begin
    // reset, then a plain ALU request
    cyc();
    cyc();
    rst = 1'b0;
    in_valid = 1'b1;
    sel = 2'd0;
    set_src(0, 32'h0000_1234);
    @(negedge clk);
    chk("rst_valid", W'(ov_a), 0);
    chk("rst_data", od_a, 0);
    chk("rst_selerr", W'(se_a), 0);
    chk("alu_stall", W'(stall_a), 0);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("alu_valid", W'(ov_a), 1);
    chk("alu_data", od_a, 32'h0000_1234);

    // memory request, ready after three idle cycles
    cyc();
    in_valid = 1'b1;
    sel = 2'd1;
    mem_rdy = 1'b0;
    set_src(1, 32'hDEAD_BEEF);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (stall_a) n++;
      cyc();
      in_valid = 1'b0;
      mem_rdy = (i + 1 == 3);
    end
    @(negedge clk);
    chk("mem_stall_cycles", W'(n), 4);
    chk("mem_valid", W'(ov_a), 1);
    chk("mem_data", od_a, 32'hDEAD_BEEF);
    chk("mem_tmo", W'(to_a), 0);

    // memory request that never gets ready
    cyc();
    in_valid = 1'b1;
    sel = 2'd1;
    mem_rdy = 1'b0;
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov_a) begin
        got = 1'b1;
        break;
      end
      if (stall_a) n++;
      cyc();
      in_valid = 1'b0;
    end
    chk("tmo_seen", W'(got), 1);
    chk("tmo_stall_cycles", W'(n), 16);
    chk("tmo_data", od_a, 0);
    chk("tmo_flag", W'(to_a), 1);
    chk("tmo_flag_b", W'(to_b), 1);
    chk("tmo_idle", W'(stall_a), 0);

    // out-of-range select on the 3-source instance
    cyc();
    in_valid = 1'b1;
    sel = 2'd2;
    set_src(2, 32'h2222_0002);
    cyc();
    sel = 2'd3;
    set_src(3, 32'hCAFE_0003);
    @(negedge clk);
    chk("b_pc4_data", od_b, 32'h2222_0002);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b_err_valid", W'(ov_b), 1);
    chk("b_err_data", od_b, 0);
    chk("b_err_flag", W'(se_b), 1);
    chk("a_imm_data", od_a, 32'hCAFE_0003);
    chk("a_imm_selerr", W'(se_a), 0);
    cyc();
    @(negedge clk);
    chk("b_hold_valid", W'(ov_b), 0);
    chk("b_hold_data", od_b, 0);

    // reset in the second wait cycle
    cyc();
    in_valid = 1'b1;
    sel = 2'd1;
    mem_rdy = 1'b0;
    cyc();
    in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_stall", W'(stall_a), 1);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_valid", W'(ov_a), 0);
    chk("rstw_data", od_a, 0);
    chk("rstw_stall_after", W'(stall_a), 0);
    cyc();
    in_valid = 1'b1;
    sel = 2'd2;
    set_src(2, 32'h0000_0040);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("pc4_valid", W'(ov_a), 1);
    chk("pc4_data", od_a, 32'h0000_0040);

    // back-to-back non-memory requests
    cyc();
    in_valid = 1'b1;
    sel = seq_s[0];
    set_src(int'(seq_s[0]), seq_d[0]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_stall%0d", i), W'(stall_a), 0);
      if (i > 0) begin
        chk($sformatf("b2b_valid%0d", i), W'(ov_a), 1);
        chk($sformatf("b2b_data%0d", i), od_a, seq_d[i-1]);
      end
      cyc();
      if (i < 3) begin
        sel = seq_s[i+1];
        set_src(int'(seq_s[i+1]), seq_d[i+1]);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_valid4", W'(ov_a), 1);
    chk("b2b_data4", od_a, seq_d[3]);

    // random traffic with varying memory readiness
    for (int blk = 0; blk < 10; blk++) begin
      p = (blk % 3 == 0) ? 5 : (blk % 3 == 1) ? 50 : 95;
      for (int i = 0; i < 300; i++) begin
        cyc();
        rst      = ($urandom_range(0, 199) == 0);
        in_valid = 1'($urandom_range(0, 1));
        sel      = 2'($urandom_range(0, 3));
        mem_rdy  = ($urandom_range(0, 99) < p);
        in_data  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    cyc();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
